// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the ALU shift/rotate datapath.
//
// Contents:
//   shift_op_t      - 3-bit operation code: RL, RLC, RR, RRC, SLA, SRA, SRL, SWAP
//   shift_state_t   - sequencer states of alu_shift_seq
//   shift_dir_left  - 1 for operations that move data towards the MSB
//
// Configuration macro: ALU_SHIFT_SWAP_EN (used by alu_shift_step and
// alu_shift_seq; this package is identical in both builds).
package alu_pkg;

    typedef enum logic [2:0] {
        RL   = 3'd0,
        RLC  = 3'd1,
        RR   = 3'd2,
        RRC  = 3'd3,
        SLA  = 3'd4,
        SRA  = 3'd5,
        SRL  = 3'd6,
        SWAP = 3'd7
    } shift_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_t;

    // Left-moving operations push the MSB into carry; everything else
    // (including SWAP, which never reads the result) uses the LSB.
    function automatic logic shift_dir_left(input shift_op_t op);
        return (op == RL) || (op == RLC) || (op == SLA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: purely combinational single bit-step of the shift unit.
//
// Parameters:
//   WIDTH   data width (even, >= 2)
// Ports:
//   op      in  shift_op_t  operation to apply
//   d       in  WIDTH       current data value
//   c       in  1           current carry value
//   d_next  out WIDTH       data after one step
//   c_next  out 1           carry after one step
//
// Configuration macro: ALU_SHIFT_SWAP_EN
//   defined   - SWAP exchanges the two halves and clears carry
//   undefined - SWAP behaves like any unrecognised code: d and c unchanged,
//               and no half-swap multiplexer is built
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  shift_op_t        op,
    input  logic [WIDTH-1:0] d,
    input  logic             c,
    output logic [WIDTH-1:0] d_next,
    output logic             c_next
);

`ifdef ALU_SHIFT_SWAP_EN
    localparam int HALF = WIDTH / 2;
`endif

    logic out_bit;

    // Every shifting operation moves exactly one data end-bit into carry,
    // so pick it once from the direction and share it across the cases.
    always_comb begin
        d_next  = d;
        c_next  = c;
        out_bit = shift_dir_left(op) ? d[WIDTH-1] : d[0];
        case (op)
            RL: begin
                d_next = {d[WIDTH-2:0], c};
                c_next = out_bit;
            end
            RLC: begin
                d_next = {d[WIDTH-2:0], d[WIDTH-1]};
                c_next = out_bit;
            end
            RR: begin
                d_next = {c, d[WIDTH-1:1]};
                c_next = out_bit;
            end
            RRC: begin
                d_next = {d[0], d[WIDTH-1:1]};
                c_next = out_bit;
            end
            SLA: begin
                d_next = {d[WIDTH-2:0], 1'b0};
                c_next = out_bit;
            end
            SRA: begin
                d_next = {d[WIDTH-1], d[WIDTH-1:1]};
                c_next = out_bit;
            end
            SRL: begin
                d_next = {1'b0, d[WIDTH-1:1]};
                c_next = out_bit;
            end
`ifdef ALU_SHIFT_SWAP_EN
            SWAP: begin
                d_next = {d[HALF-1:0], d[WIDTH-1:HALF]};
                c_next = 1'b0;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: sequential shift/rotate unit, one bit-step per clock,
// driven by the ALU control sequencer through start/busy/done.
//
// Parameters:
//   WIDTH   data width (even, >= 2), default 8
//   CNT_W   width of the step count, default 4
// Ports:
//   clk          in  1      clock, rising edge
//   nreset       in  1      asynchronous active-low reset
//   start        in  1      request, sampled on the rising edge
//   op           in  3      shift_op_t operation
//   src          in  WIDTH  operand, sampled with start
//   cin          in  1      carry-in, sampled with start
//   count        in  CNT_W  number of bit-steps (ignored for SWAP)
//   shift_early  out 1      combinational: bit the first step of the
//                           presented request moves into carry
//   busy         out 1      operation in progress, including the done cycle
//   done         out 1      one-cycle pulse, result/cout/zero valid
//   result       out WIDTH  shifted value (held until the next start)
//   cout         out 1      final carry (held until the next start)
//   zero         out 1      result == 0
//
// Configuration macro: ALU_SHIFT_SWAP_EN
//   defined   - SWAP runs as a single half-exchange step
//   undefined - SWAP completes as a zero-step pass-through
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  shift_op_t        op,
    input  logic [WIDTH-1:0] src,
    input  logic             cin,
    input  logic [CNT_W-1:0] count,
    output logic             shift_early,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    shift_state_t     state_q, state_d;
    shift_op_t        op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic             load_ok;
    shift_op_t        unit_op;
    logic [WIDTH-1:0] unit_d;
    logic             unit_c;
    logic [WIDTH-1:0] step_d;
    logic             step_c;
    logic [CNT_W-1:0] load_rem;

    // A request can only be taken while idle or in the done cycle; in both
    // the registers are not stepping, so the single step unit is lent to
    // the incoming operand to produce shift_early. Feeding carry 0 makes
    // SWAP (and pass-through codes) report 0.
    assign load_ok = (state_q == IDLE) || (rem_q == '0);
    assign unit_op = load_ok ? op  : op_q;
    assign unit_d  = load_ok ? src : data_q;
    assign unit_c  = load_ok ? 1'b0 : carry_q;

    alu_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op     (unit_op),
        .d      (unit_d),
        .c      (unit_c),
        .d_next (step_d),
        .c_next (step_c)
    );

    assign shift_early = step_c;

    // Steps to run for the presented request. SWAP is a fixed single step
    // when built in; otherwise it completes with no step at all.
    always_comb begin
        load_rem = count;
        if (op == SWAP) begin
`ifdef ALU_SHIFT_SWAP_EN
            load_rem = CNT_W'(1);
`else
            load_rem = '0;
`endif
        end
    end

    // Next-state logic: the done cycle doubles as a load slot so the
    // sequencer can issue back-to-back operations without an idle gap.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    op_d    = op;
                    data_d  = src;
                    carry_d = cin;
                    rem_d   = load_rem;
                end
            end
            SHIFT: begin
                if (rem_q != '0) begin
                    data_d  = step_d;
                    carry_d = step_c;
                    rem_d   = rem_q - CNT_W'(1);
                end else if (start) begin
                    op_d    = op;
                    data_d  = src;
                    carry_d = cin;
                    rem_d   = load_rem;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            op_q    <= RL;
            data_q  <= '0;
            carry_q <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == SHIFT) && (rem_q == '0);
    assign result = data_q;
    assign cout   = carry_q;
    assign zero   = (data_q == '0);

endmodule

// File: doc/alu_shift_seq.md
# alu_shift_seq

Sequential, parametrised shift/rotate unit for the CPU ALU datapath. It generalises the single-step 8-bit rotate-through-carry to any WIDTH, a programmable step count, and the full SM83 shift family. It performs one bit-step per clock and reports carry-out and zero with the result. It sits beside the adder in the ALU and is driven by the control sequencer through a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: data width; must be even and ≥ 2.
- `CNT_W`, default 4: width of the step count; at most 2^CNT_W−1 steps.
- `clk`  in  1  clock; all state changes on the rising edge.
- `nreset`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled on the rising edge.
- `op`  in  3  `shift_op_t`: RL, RLC, RR, RRC, SLA, SRA, SRL, SWAP.
- `src`  in  WIDTH  operand; sampled with `start`.
- `cin`  in  1  carry-in; sampled with `start`.
- `count`  in  CNT_W  number of bit-steps; sampled with `start`; ignored for SWAP.
- `shift_early`  out  1  combinational: bit that the first step moves into carry (`src[WIDTH-1]` for left ops, `src[0]` for right ops, 0 for SWAP).
- `busy`  out  1  an operation is in progress; includes the done cycle.
- `done`  out  1  one-cycle pulse; `result`, `cout` and `zero` are valid.
- `result`  out  WIDTH  shifted value.
- `cout`  out  1  final carry.
- `zero`  out  1  `result == 0`.

## Operation
- States: IDLE, SHIFT.
- IDLE + `start`: load the data register from `src`, the carry register from `cin` and `rem` from `count` (1 for SWAP), then go to SHIFT.
- SHIFT with `rem > 0`: perform one step and decrement `rem`.
- SHIFT with `rem == 0`: `done = 1`.
  - `start` in this cycle is accepted and handled as the IDLE load, giving back-to-back operation.
  - Otherwise the next state is IDLE.
- Step definitions, with d = data register and c = carry register:
  - RL: {c,d} ← {d, c}.
  - RLC: c ← d[MSB]; d ← {d[MSB-1:0], d[MSB]}.
  - RR: {d,c} ← {c, d}.
  - RRC: c ← d[0]; d ← {d[0], d[MSB:1]}.
  - SLA: {c,d} ← {d, 0}.
  - SRA: c ← d[0]; d ← {d[MSB], d[MSB:1]}.
  - SRL: c ← d[0]; d ← {0, d[MSB:1]}.
  - SWAP: d ← {lower half, upper half}; c ← 0.
- `count == 0` (non-SWAP): no step is performed. `result = src` and `cout = cin`.
- `start` in SHIFT while `rem > 0` is ignored; there is no queueing.
- `result`, `cout` and `zero` hold their values after `done` until the next accepted `start`.
- The reserved `op` encoding, and SWAP when it is compiled out, complete as `count == 0` (pass-through).

## Timing
- Reset values: state IDLE, `busy = 0`, `done = 0`, `result = 0`, `cout = 0`, `zero = 1`.
- `nreset` asserted mid-operation aborts immediately. No `done` is produced for the aborted operation.
- Latency: `start` is accepted at edge E. `busy` is high from E; `done` is high in the cycle after edge E+N, where N = steps (1 for SWAP).
- `zero` is derived combinationally from the data register. It is valid whenever `done` is high or the block is idle.
- `shift_early` has no registered delay.

## Configuration
- `ALU_SHIFT_SWAP_EN` defined: SWAP is implemented as specified.
- `ALU_SHIFT_SWAP_EN` undefined: the SWAP encoding is treated as reserved (pass-through). The half-swap multiplexer is not synthesised.

## Structure
- Package `alu_pkg` holds:
  - `shift_op_t` (3-bit enum, with RL = 0 … SWAP = 7 in the order listed);
  - `shift_state_t`;
  - the `shift_dir_left(op)` function.
- Sub-module `alu_shift_step`: a purely combinational single-step unit.
  - Inputs: `op`, `d`, `c`.
  - Outputs: next `d`, next `c`.
  - The same unit also drives `shift_early`.
- The top level holds the FSM, `rem`, and the data and carry registers.

## Test plan
- RL, WIDTH=8, src=0x80, cin=0, count=1 → `done` after 1 step; result=0x00, cout=1, zero=1.
- RRC, src=0x01, cin=0, count=3 → result=0x20, cout=0, zero=0; `busy` high for 4 cycles. `shift_early=1` in the start cycle.
- SRA, src=0x81, count=2 → result=0xE0, cout=0. A `start` issued mid-operation is ignored.
- SWAP, src=0xA5, cin=1 → result=0x5A, cout=0, with `done` after 1 cycle.
  - With `ALU_SHIFT_SWAP_EN` undefined: result=0xA5, cout=1.
- count=0, src=0x3C, cin=1 → `done` on the first cycle; result=0x3C, cout=1. A second `start` in that done cycle is accepted back-to-back.
- `nreset` pulsed during an RL with count=7 → all outputs at reset values; no `done` until a new `start`.
- WIDTH=16: RL of 0x8001 with cin=1, count=1 → result=0x0003, cout=1.
